// File: rtl/param_arb_pkg.sv
// Shared types and helpers for the parameter-ROM read arbiter: ROM latency, the
// in-flight tag carried alongside each read, and the round-robin pick function.
package param_arb_pkg;

    localparam int ROM_LATENCY = 2;
    localparam int MAX_REQ     = 16;
    localparam int ID_W        = $clog2(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            last;
    } arb_tag_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] id;
    } arb_pick_t;

    // First eligible requester at or after ptr, wrapping modulo n_req.
    function automatic arb_pick_t rr_pick(input logic [MAX_REQ-1:0] eligible,
                                          input logic [ID_W-1:0]    ptr,
                                          input int                 n_req);
        arb_pick_t pick;
        int        idx;
        pick = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % n_req;
            if (k < n_req && eligible[idx[ID_W-1:0]]) begin
                pick.found = 1'b1;
                pick.id    = idx[ID_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/param_arb_fifo.sv
// Per-requester synchronous FIFO holding {last, data}; head is presented straight
// from the storage registers and the occupancy count feeds the credit logic.
module param_arb_fifo #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [DWIDTH-1:0]            push_data_i,
    input  logic                         push_last_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [DWIDTH-1:0]            data_o,
    output logic                         last_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DWIDTH:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal driven here gets a value before any condition, so no latch can form.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
    end

    assign valid_o          = (count_q != '0);
    assign {last_o, data_o} = mem_q[rd_ptr_q];
    assign count_o          = count_q;

endmodule

// File: rtl/param_rom_read_arbiter.sv
// Round-robin, credit-gated sharing of one 2-cycle ROM read port among N_REQ streams.
// Define PARAM_ARB_PERF_EN to add per-requester saturating stall counters (perf_stall_cnt).
module param_rom_read_arbiter
    import param_arb_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int DWIDTH     = 16,
    parameter int REQ_DEPTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ROM_AWIDTH = $clog2(N_REQ * REQ_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_en,
    output logic [ROM_AWIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DWIDTH-1:0]     rom_q,
    output logic [DWIDTH-1:0]     data_out [N_REQ],
    output logic [N_REQ-1:0]      data_out_valid,
    input  logic [N_REQ-1:0]      data_out_ready,
    output logic [N_REQ-1:0]      data_out_last
`ifdef PARAM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt [N_REQ]
`endif
);

    localparam int CNT_W  = $clog2(REQ_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0]      cnt_q [N_REQ];
    logic [CNT_W-1:0]      cnt_d [N_REQ];
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ROM_AWIDTH-1:0] addr_q, addr_d;
    arb_tag_t              tag_q [ROM_LATENCY];
    arb_tag_t              tag_d;
    arb_tag_t              tag_out;
    logic [MAX_REQ-1:0]    eligible;
    arb_pick_t             pick;
    logic [CNT_W-1:0]      sel_cnt;
    logic [FCNT_W-1:0]     fifo_count [N_REQ];
    logic [N_REQ-1:0]      push;
    int                    inflight;

    always_comb begin
        eligible = '0;
        inflight = 0;
        // Credit = FIFO space not yet promised to a read still travelling through the ROM.
        for (int i = 0; i < N_REQ; i++) begin
            inflight = 0;
            for (int s = 0; s < ROM_LATENCY; s++) begin
                if (tag_q[s].valid && tag_q[s].id == ID_W'(i)) inflight = inflight + 1;
            end
            eligible[i] = !rst && req_en[i] && (int'(fifo_count[i]) + inflight < FIFO_DEPTH);
        end
        pick = rr_pick(eligible, rr_ptr_q, N_REQ);

        sel_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick.id == ID_W'(i)) sel_cnt = cnt_q[i];
        end

        addr_d   = addr_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        tag_d    = '{valid: pick.found, id: pick.id, last: (sel_cnt == CNT_W'(REQ_DEPTH - 1))};
        if (pick.found) begin
            addr_d   = ROM_AWIDTH'(int'(pick.id) * REQ_DEPTH + int'(sel_cnt));
            rr_ptr_d = (pick.id == ID_W'(N_REQ - 1)) ? '0 : pick.id + ID_W'(1);
            for (int i = 0; i < N_REQ; i++) begin
                if (pick.id == ID_W'(i))
                    cnt_d[i] = (sel_cnt == CNT_W'(REQ_DEPTH - 1)) ? '0 : sel_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            addr_q   <= '0;
            cnt_q    <= '{default: '0};
            for (int s = 0; s < ROM_LATENCY; s++) tag_q[s] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            tag_q[0] <= tag_d;
            for (int s = 1; s < ROM_LATENCY; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Address holds its last value when idle; reset forces the base address.
    assign rom_addr = rst ? '0 : addr_d;
    assign rom_ce   = 1'b1;
    assign tag_out  = tag_q[ROM_LATENCY-1];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign push[gi] = tag_out.valid && (tag_out.id == ID_W'(gi));

        param_arb_fifo #(
            .DWIDTH (DWIDTH),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (push[gi]),
            .push_data_i (rom_q),
            .push_last_i (tag_out.last),
            .pop_i       (data_out_ready[gi]),
            .valid_o     (data_out_valid[gi]),
            .data_o      (data_out[gi]),
            .last_o      (data_out_last[gi]),
            .count_o     (fifo_count[gi])
        );

`ifdef PARAM_ARB_PERF_EN
        logic [31:0] perf_q;
        // Counts every requesting cycle without a grant: credit-starved or lost arbitration.
        always_ff @(posedge clk) begin
            if (rst)
                perf_q <= '0;
            else if (req_en[gi] && !(pick.found && pick.id == ID_W'(gi)) && perf_q != '1)
                perf_q <= perf_q + 32'd1;
        end
        assign perf_stall_cnt[gi] = perf_q;
`endif
    end

endmodule

// File: tb/tb_param_rom_read_arbiter.sv
// Directed bench for param_rom_read_arbiter: ROM model with word k = k, per-lane
// scoreboard queues, and latency/rate/stall/reset checks (perf checks with PARAM_ARB_PERF_EN).
module tb_param_rom_read_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int RD = 32;
    localparam int FD = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_en;
    logic [N-1:0]  ready;
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] data_out [N];
    logic [AW-1:0] rom_p1;
`ifdef PARAM_ARB_PERF_EN
    logic [31:0]   perf [N];
`endif

    int            tests = 0;
    int            fails = 0;
    int            xfer [N] = '{default: 0};
    int            pos  [N] = '{default: 0};
    logic [16:0]   exp_q [N][$];

    always #5 clk = ~clk;

    param_rom_read_arbiter #(
        .N_REQ      (N),
        .DWIDTH     (DW),
        .REQ_DEPTH  (RD),
        .FIFO_DEPTH (FD),
        .ROM_AWIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_en         (req_en),
        .rom_addr       (rom_addr),
        .rom_ce         (rom_ce),
        .rom_q          (rom_q),
        .data_out       (data_out),
        .data_out_valid (valid),
        .data_out_ready (ready),
        .data_out_last  (last)
`ifdef PARAM_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf)
`endif
    );

    // ROM: word k holds value k, data appears two cycles after the address.
    always @(posedge clk) begin
        rom_p1 <= rom_addr;
        rom_q  <= 16'(rom_p1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int lane, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q[lane].push_back({pos[lane] == RD - 1, 16'(lane * RD + pos[lane])});
            pos[lane] = (pos[lane] + 1) % RD;
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            pos[i] = 0;
        end
    endtask

    // Scoreboard: every handshake pops the lane's next expected {last, data}.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < N; i++) begin
                if (valid[i] && ready[i]) begin
                    logic [16:0] e;
                    check($sformatf("lane%0d_expected_avail", i), 32'(exp_q[i].size() != 0), 32'd1);
                    if (exp_q[i].size() != 0) begin
                        e = exp_q[i].pop_front();
                        check($sformatf("lane%0d_data", i), 32'(data_out[i]), 32'(e[15:0]));
                        check($sformatf("lane%0d_last", i), 32'(last[i]), 32'(e[16]));
                    end
                    xfer[i]++;
                end
            end
        end
    end

    initial begin
        int          snap [N];
        int          waited;
        logic [16:0] head;

        rst = 1'b1; req_en = '0; ready = '0;
        tick(3);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_ce", 32'(rom_ce), 32'd1);
        rst = 1'b0;
        tick(1);

        // 1: lone requester, latency 3, full rate, last on 31 and wrap.
        push_exp(0, 40);
        ready = 3'b111; req_en = 3'b001;
        #1;
        check("t1_addr_first", 32'(rom_addr), 32'd0);
        check("t1_valid_T0", 32'(valid[0]), 32'd0);
        tick(1);
        check("t1_addr_second", 32'(rom_addr), 32'd1);
        tick(1);
        check("t1_valid_T2", 32'(valid[0]), 32'd0);
        tick(1);
        check("t1_valid_T3", 32'(valid[0]), 32'd1);
        check("t1_data_T3", 32'(data_out[0]), 32'd0);
        snap[0] = xfer[0];
        tick(32);
        check("t1_rate", 32'(xfer[0] - snap[0]), 32'd32);
        tick(2);
        req_en = '0;
        tick(10);
        check("t1_drained", 32'(valid), 32'd0);

        // 2: all requesters, rotation from lane 1, each lane at 1/3 rate.
        push_exp(0, 40); push_exp(1, 40); push_exp(2, 40);
        req_en = 3'b111;
        #1;
        check("t2_addr_lane1", 32'(rom_addr), 32'd32);
        tick(1);
        check("t2_addr_lane2", 32'(rom_addr), 32'd64);
        tick(4);
        for (int i = 0; i < N; i++) snap[i] = xfer[i];
        tick(30);
        for (int i = 0; i < N; i++) check($sformatf("t2_rate_lane%0d", i), 32'(xfer[i] - snap[i]), 32'd10);
        req_en = '0;
        tick(10);
        check("t2_drained", 32'(valid), 32'd0);

        // 3: consumer 0 stalled: valid held, head stable, exactly FIFO_DEPTH issued.
        push_exp(0, 20);
        req_en = 3'b001; ready = 3'b110;
        tick(5);
        head = exp_q[0][0];
        check("t3_valid_held_a", 32'(valid[0]), 32'd1);
        check("t3_data_stable_a", 32'(data_out[0]), 32'(head[15:0]));
        tick(14);
        check("t3_valid_held_b", 32'(valid[0]), 32'd1);
        check("t3_data_stable_b", 32'(data_out[0]), 32'(head[15:0]));
        check("t3_last_stable_b", 32'(last[0]), 32'(head[16]));
        snap[0] = xfer[0];
        ready = 3'b111; req_en = '0;
        tick(10);
        check("t3_issued", 32'(xfer[0] - snap[0]), FD);

        // 4: drop req_en after 10 issues, resume where the count stopped.
        push_exp(0, 40);
        snap[0] = xfer[0];
        req_en = 3'b001;
        #1;
        head = exp_q[0][0];
        check("t4_start_addr", 32'(rom_addr), 32'(head[15:0]));
        tick(10);
        req_en = '0;
        tick(5);
        req_en = 3'b001;
        #1;
        head = exp_q[0][0];
        check("t4_resume_addr", 32'(rom_addr), 32'(head[15:0]));
        tick(15);
        req_en = '0;
        tick(10);
        check("t4_total", 32'(xfer[0] - snap[0]), 32'd25);

        // 5: reset mid-stream discards in-flight reads; restart at entry 0.
        push_exp(0, 40); push_exp(1, 40); push_exp(2, 40);
        req_en = 3'b111;
        tick(8);
        rst = 1'b1;
        clear_exp();
        tick(1);
        check("t5_valid_after_rst", 32'(valid), 32'd0);
        check("t5_addr_in_rst", 32'(rom_addr), 32'd0);
        tick(1);
        rst = 1'b0; req_en = 3'b001;
        push_exp(0, 40);
        waited = 0;
        while (!valid[0] && waited < 10) begin
            tick(1);
            waited++;
        end
        check("t5_valid_timeout", 32'(valid[0]), 32'd1);
        check("t5_first_data", 32'(data_out[0]), 32'd0);
        check("t5_latency", 32'(waited), 32'd3);
        tick(10);
        req_en = '0;
        tick(10);

`ifdef PARAM_ARB_PERF_EN
        // 6: lane 2 not ready; it loses or starves on 7 of 10 cycles, lane 0 loses on 6.
        rst = 1'b1;
        clear_exp();
        tick(2);
        check("t6_perf_cleared", perf[2], 32'd0);
        push_exp(0, 20); push_exp(1, 20); push_exp(2, 20);
        rst = 1'b0; req_en = 3'b111; ready = 3'b011;
        tick(10);
        check("t6_perf_lane2", perf[2], 32'd7);
        check("t6_perf_lane0", perf[0], 32'd6);
        ready = 3'b111; req_en = '0;
        tick(10);
`endif

        check("final_drained", 32'(valid), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
